// File: rtl/store_unit_if.sv
// ============================================================================
// Module      : store_unit_if
// Description : Request and data-memory write bundle for store_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface store_unit_if #(
   parameter int ADDR_W = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        funct3;
   logic [31:0]       base;
   logic [31:0]       offset;
   logic [31:0]       wdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              err_misalign;

   modport master (
      output req_valid, funct3, base, offset, wdata,
      input  req_ready, mem_we, mem_addr, mem_wdata, busy, done, err_misalign
   );

   modport slave (
      input  req_valid, funct3, base, offset, wdata,
      output req_ready, mem_we, mem_addr, mem_wdata, busy, done, err_misalign
   );
endinterface

`default_nettype wire

// File: rtl/store_unit.sv
// ============================================================================
// Module      : store_unit
// Description : Byte-serial SB/SH/SW store unit; writes the selected bytes
//               little-endian into byte-wide data memory, one per cycle.
//               Optional macro STORE_ALIGN_CHECK_EN enables misalign faults.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module store_unit #(
   parameter int ADDR_W = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   store_unit_if.slave   bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   state_t            r_state, w_state_nx;
   logic [1:0]        r_k, w_k_nx;
   logic [1:0]        r_last, w_last_nx;
   logic [ADDR_W-1:0] r_ea, w_ea_nx;
   logic [31:0]       r_data, w_data_nx;
   logic              r_wr, w_wr_nx;
   logic              r_we, w_we_nx;
   logic [ADDR_W-1:0] r_addr, w_addr_nx;
   logic [7:0]        r_byte, w_byte_nx;
   logic              r_done, w_done_nx;
   logic              r_err, w_err_nx;

   logic              w_on_last;
   logic              w_accept;
   logic [ADDR_W-1:0] w_ea_req;
   logic              w_f3_ok;
   logic              w_misalign;
   logic              w_write_req;
   logic [1:0]        w_last_req;
   logic [1:0]        w_k_inc;

   assign w_on_last     = (r_state == S_WRITE) && (r_k == r_last);
   assign bus.req_ready = rst_n && ((r_state == S_IDLE) || w_on_last);
   assign w_accept      = bus.req_valid && bus.req_ready;
   assign w_ea_req      = ADDR_W'(bus.base + bus.offset);
   assign w_f3_ok       = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                          (bus.funct3 == 3'b010);

`ifdef STORE_ALIGN_CHECK_EN
   assign w_misalign = ((bus.funct3 == 3'b001) && w_ea_req[0]) ||
                       ((bus.funct3 == 3'b010) && (w_ea_req[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_write_req = w_f3_ok && !w_misalign;
   assign w_k_inc     = r_k + 2'd1;

   // Rejected requests (invalid or faulting) collapse to a single silent beat.
   always_comb begin
      w_last_req = 2'd0;
      if (w_write_req) begin
         case (bus.funct3)
            3'b001:  w_last_req = 2'd1;
            3'b010:  w_last_req = 2'd3;
            default: w_last_req = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
         r_last  <= 2'd0;
         r_ea    <= '0;
         r_data  <= 32'd0;
         r_wr    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_byte  <= 8'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_k     <= w_k_nx;
         r_last  <= w_last_nx;
         r_ea    <= w_ea_nx;
         r_data  <= w_data_nx;
         r_wr    <= w_wr_nx;
         r_we    <= w_we_nx;
         r_addr  <= w_addr_nx;
         r_byte  <= w_byte_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   // Output registers always hold the beat currently on the memory port.
   always_comb begin
      w_state_nx = r_state;
      w_k_nx     = r_k;
      w_last_nx  = r_last;
      w_ea_nx    = r_ea;
      w_data_nx  = r_data;
      w_wr_nx    = r_wr;
      w_we_nx    = 1'b0;
      w_addr_nx  = '0;
      w_byte_nx  = 8'd0;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      if (w_accept) begin
         w_state_nx = S_WRITE;
         w_k_nx     = 2'd0;
         w_last_nx  = w_last_req;
         w_ea_nx    = w_ea_req;
         w_data_nx  = bus.wdata;
         w_wr_nx    = w_write_req;
         w_we_nx    = w_write_req;
         w_addr_nx  = w_write_req ? w_ea_req : '0;
         w_byte_nx  = w_write_req ? bus.wdata[7:0] : 8'd0;
         w_done_nx  = (w_last_req == 2'd0);
         w_err_nx   = w_misalign;
      end else if (r_state == S_WRITE) begin
         if (w_on_last) begin
            w_state_nx = S_IDLE;
         end else begin
            w_k_nx    = w_k_inc;
            w_we_nx   = r_wr;
            w_addr_nx = r_ea + ADDR_W'(w_k_inc);
            w_byte_nx = r_data[{w_k_inc, 3'b000} +: 8];
            w_done_nx = (w_k_inc == r_last);
         end
      end
   end

   assign bus.mem_we       = r_we;
   assign bus.mem_addr     = r_addr;
   assign bus.mem_wdata    = r_byte;
   assign bus.done         = r_done;
   assign bus.err_misalign = r_err;
   assign bus.busy         = (r_state == S_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
// ============================================================================
// Module      : tb_store_unit
// Description : Scoreboard bench for store_unit (directed vectors).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_store_unit;
   localparam int ADDR_W = 3;

   typedef struct packed {
      logic       we;
      logic [2:0] addr;
      logic [7:0] data;
      logic       done;
      logic       err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   exp_t m_e;

   always #5 clk = ~clk;

   store_unit_if #(.ADDR_W(ADDR_W)) bus ();
   store_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic we, input logic [2:0] addr, input logic [7:0] data,
                       input logic done, input logic err);
      exp_t e;
      e.we = we; e.addr = addr; e.data = data; e.done = done; e.err = err;
      q.push_back(e);
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] off,
                        input logic [31:0] wd);
      int n;
      bus.funct3 = f3; bus.base = b; bus.offset = off; bus.wdata = wd;
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.req_ready) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.busy) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (q.size() != 0 || bus.busy) chk("idle_timeout", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
      chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_done"},  32'(bus.done), 32'd0);
      chk({tag, "_err"},   32'(bus.err_misalign), 32'd0);
   endtask

   // Scoreboard monitor: every observable beat must match the queue head.
   always @(negedge clk) begin
      if (bus.mem_we || bus.done || bus.err_misalign) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: we=%0b addr=%0d data=0x%0h done=%0b err=%0b, want none",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done, bus.err_misalign);
         end else begin
            m_e = q.pop_front();
            chk("beat_we", 32'(bus.mem_we), 32'(m_e.we));
            if (m_e.we) begin
               chk("beat_addr", 32'(bus.mem_addr), 32'(m_e.addr));
               chk("beat_data", 32'(bus.mem_wdata), 32'(m_e.data));
            end
            chk("beat_done", 32'(bus.done), 32'(m_e.done));
            chk("beat_err", 32'(bus.err_misalign), 32'(m_e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0; bus.funct3 = 3'd0;
      bus.base = 32'd0; bus.offset = 32'd0; bus.wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      #1;
      chk("ready_idle", 32'(bus.req_ready), 32'd1);

      // SW at 0: four bytes LSB first, ready low until the last beat
      push(1, 3'd0, 8'h44, 0, 0); push(1, 3'd1, 8'h33, 0, 0);
      push(1, 3'd2, 8'h22, 0, 0); push(1, 3'd3, 8'h11, 1, 0);
      issue(3'b010, 32'd0, 32'd0, 32'h11223344);
      chk("sw_ready_t1", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1; chk("sw_ready_t2", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1; chk("sw_ready_t3", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1; chk("sw_ready_t4", 32'(bus.req_ready), 32'd1);
      wait_idle();

      // SB with negative offset: ea = 5 - 1 = 4
      push(1, 3'd4, 8'hDD, 1, 0);
      issue(3'b000, 32'd5, 32'hFFFF_FFFF, 32'hAABBCCDD);
      wait_idle();

      // SH at 2 chained with SB at 7, busy held throughout
      push(1, 3'd2, 8'hEF, 0, 0); push(1, 3'd3, 8'hBE, 1, 0); push(1, 3'd7, 8'h5A, 1, 0);
      fork
         begin
            issue(3'b001, 32'd2, 32'd0, 32'h0000BEEF);
            issue(3'b000, 32'd7, 32'd0, 32'h0000005A);
         end
         begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("chain_busy", 32'(bus.busy), 32'd1);
            end
         end
      join
      wait_idle();

      // SW at 6: wraps, or faults when alignment checking is built in
`ifdef STORE_ALIGN_CHECK_EN
      push(0, 3'd0, 8'h00, 1, 1);
`else
      push(1, 3'd6, 8'h04, 0, 0); push(1, 3'd7, 8'h03, 0, 0);
      push(1, 3'd0, 8'h02, 0, 0); push(1, 3'd1, 8'h01, 1, 0);
`endif
      issue(3'b010, 32'd6, 32'd0, 32'h01020304);
      wait_idle();

      // SH at 3 (base 1 + offset 2)
`ifdef STORE_ALIGN_CHECK_EN
      push(0, 3'd0, 8'h00, 1, 1);
`else
      push(1, 3'd3, 8'h34, 0, 0); push(1, 3'd4, 8'h12, 1, 0);
`endif
      issue(3'b001, 32'd1, 32'd2, 32'h00001234);
      wait_idle();

      // Invalid funct3: one silent beat with done
      push(0, 3'd0, 8'h00, 1, 0);
      issue(3'b111, 32'd1, 32'd2, 32'hFFFFFFFF);
      wait_idle();

      // SW aborted by reset after the second beat
      push(1, 3'd0, 8'h0D, 0, 0); push(1, 3'd1, 8'hF0, 0, 0);
      issue(3'b010, 32'd0, 32'd0, 32'hCAFEF00D);
      @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("abort");
      chk("abort_sb", 32'(q.size()), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;

      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/store_unit.md
# store_unit

Byte-serial store unit for the exec stage: accepts one SB/SH/SW request (funct3, base register value, S-type immediate, store data) and writes the selected bytes little-endian into the byte-wide data memory, one byte per cycle. It is the write-side counterpart of the exec-stage load path (LB/LH/LW), which reads `data_memory` at `imm_i_type + rs1Data` and assembles bytes LSB-first. A registered valid/ready handshake on the request side and a registered write port on the memory side make the block the only writer of data memory.

## Interface
- `ADDR_W`, 3, data-memory byte-address width; memory depth is 2^ADDR_W bytes.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  store request present
- `req_ready`  out  1  unit can accept a request this cycle
- `funct3`  in  3  000=SB, 001=SH, 010=SW, anything else = invalid
- `base`  in  32  rs1 register value
- `offset`  in  32  imm_s_type, already sign-extended
- `wdata`  in  32  rs2 register value; low 1/2/4 bytes stored
- `mem_we`  out  1  byte write strobe
- `mem_addr`  out  ADDR_W  byte address
- `mem_wdata`  out  8  byte data
- `busy`  out  1  request in progress
- `done`  out  1  one-cycle pulse on the last beat of a request
- `err_misalign`  out  1  one-cycle misalignment pulse (see Configuration)

## Operation
- Two states: IDLE, WRITE. Reset → IDLE.
- Accept when `req_valid && req_ready`. Capture funct3, `ea = (base + offset)[ADDR_W-1:0]` (32-bit add, truncated), and wdata. Set beat count N: SB=1, SH=2, SW=4. Set 2-bit byte index k=0. Go to WRITE.
- In WRITE, each cycle drives `mem_we=1`, `mem_addr = ea + k` mod 2^ADDR_W, `mem_wdata = wdata[8k+7:8k]`, then k++. Byte 0 goes first.
- The last beat (k==N-1) asserts `done`. If another request is accepted in that cycle, the unit restarts WRITE with k=0. Otherwise it returns to IDLE.
- Invalid funct3: the request is accepted and takes one beat with `mem_we=0` and `done=1`. Nothing is written.
- Address wrap: address bytes past 2^ADDR_W-1 wrap to 0. For example, SW at ea=6 with ADDR_W=3 writes addresses 6, 7, 0, 1.
- Input fields are sampled only on the accept cycle. Changes outside that cycle are ignored.

## Timing
- Reset values: `req_ready=0` while `rst_n=0`, then 1 in IDLE. `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `done=0`, `err_misalign=0`.
- `mem_we`, `mem_addr`, `mem_wdata`, `done` and `err_misalign` are registered outputs. `req_ready` is combinational: it is 1 in IDLE or on the last WRITE beat.
- Latency: accept at cycle T; first byte write at T+1; last byte write and `done` at T+N.
- Throughput: back-to-back requests take N cycles each with no bubble.
- `busy` = 1 from T+1 through T+N, and stays 1 across chained requests.
- Reset mid-request: the next edge with `rst_n=0` aborts the request. Remaining bytes are not written, no `done` is issued, and the captured request is discarded.
- `req_valid` held without `req_ready`: the request stays pending and is not captured. Requests are never dropped.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - SH with `ea[0]!=0`, or SW with `ea[1:0]!=0`, is accepted and takes one beat with `mem_we=0`, `done=1` and `err_misalign=1`. No bytes are written.
  - SB never faults.
- `STORE_ALIGN_CHECK_EN` undefined:
  - Misaligned SH/SW write byte-serially with wrap, as described in Operation.
  - `err_misalign` is tied to 0.

## Test plan
- Reset, then SW with base=0, offset=0, wdata=0x11223344 → mem writes (0,0x44), (1,0x33), (2,0x22), (3,0x11) at T+1..T+4; `done` at T+4; `req_ready` low at T+1..T+3.
- SB with base=5, offset=0xFFFFFFFF (−1), wdata=0xAABBCCDD → single write (4,0xDD) at T+1; `done` at T+1.
- SH with ea=2, wdata=0xBEEF, immediately followed by SB with ea=7, wdata=0x5A held valid → writes (2,0xEF), (3,0xBE), (7,0x5A) on three consecutive cycles; `done` at the 2nd and 3rd beats; `busy` high continuously.
- SW at ea=6 with wdata=0x01020304: without macro → writes (6,04), (7,03), (0,02), (1,01); with `STORE_ALIGN_CHECK_EN` → no writes, `done=1` and `err_misalign=1` at T+1.
- funct3=3'b111 → accepted, `mem_we` never asserted, `done` at T+1.
- SW started, `rst_n=0` on the edge after the 2nd beat → only bytes 0 and 1 written, no `done`, all outputs at reset values, `req_ready=1` in the first cycle after `rst_n` returns high.
